dmem_arbiter: RTL and testbench

//  Arbitrates the single-port data memory between the pipeline MEM stage (port P, driven from EX/MEM)
//  and an external loader/debug master (port X). Pipeline has priority; a wait counter plus a 3-state
//  FSM force a bounded-latency grant to X, stalling the pipeline for exactly that cycle.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline MEM stage has priority, and the external
// loader/debug master gets a forced grant after MAX_WAIT consecutive denials.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_re,
    input  logic                  p_we,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_funct3,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_stall,
    input  logic                  x_req,
    input  logic                  x_we,
    input  logic [DM_ADDRESS-1:0] x_addr,
    input  logic [DATA_W-1:0]     x_wdata,
    input  logic [2:0]            x_funct3,
    output logic                  x_gnt,
    output logic                  x_rvalid,
    output logic [DATA_W-1:0]     x_rdata,
    output logic                  m_re,
    output logic                  m_we,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_funct3,
    input  logic [DATA_W-1:0]     m_rdata
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {P_PRI, X_FORCE, COOLDOWN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d, cnt_inc;
    logic               x_rvalid_q;
    logic [DATA_W-1:0]  x_rdata_q;
    logic               p_req;

    assign p_req   = p_re | p_we;
    assign cnt_inc = wait_cnt_q + CNT_W'(1);

    // In X_FORCE, X wins whenever it is still requesting; otherwise P wins.
    assign x_gnt   = ~reset & x_req & ((state_q == X_FORCE) | ~p_req);
    assign p_stall = x_gnt & p_req;

    // A simultaneous p_re/p_we is treated as a store, so the read is suppressed.
    assign m_re     = ~reset & (x_gnt ? ~x_we : (p_re & ~p_we));
    assign m_we     = ~reset & (x_gnt ? x_we : p_we);
    assign m_addr   = x_gnt ? x_addr   : p_addr;
    assign m_wdata  = x_gnt ? x_wdata  : p_wdata;
    assign m_funct3 = x_gnt ? x_funct3 : p_funct3;
    assign p_rdata  = m_rdata;

    assign x_rvalid = x_rvalid_q;
    assign x_rdata  = x_rdata_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            P_PRI: begin
                if (x_req && p_req) begin
                    if (cnt_inc == CNT_MAX) state_d = X_FORCE;
                    else                    wait_cnt_d = cnt_inc;
                end
            end
            X_FORCE: state_d = COOLDOWN;
            default: state_d = P_PRI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= P_PRI;
            wait_cnt_q <= '0;
            x_rvalid_q <= 1'b0;
            x_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            x_rvalid_q <= x_gnt & ~x_we;
            if (x_gnt && !x_we) x_rdata_q <= m_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter (MAX_WAIT=4), plus hand-written
// reset sequences.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p_re, p_we, x_req, x_we;
    logic [8:0]  p_addr, x_addr;
    logic [31:0] p_wdata, x_wdata, m_rdata;
    logic [2:0]  p_funct3, x_funct3;
    logic [31:0] p_rdata, x_rdata, m_wdata;
    logic        p_stall, x_gnt, x_rvalid, m_re, m_we;
    logic [8:0]  m_addr;
    logic [2:0]  m_funct3;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .p_re(p_re), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_funct3(p_funct3), .p_rdata(p_rdata), .p_stall(p_stall),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_funct3(x_funct3), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_funct3(m_funct3), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p_re, p_we;
        logic [8:0]  p_addr;
        logic [31:0] p_wdata;
        logic        x_req, x_we;
        logic [8:0]  x_addr;
        logic [31:0] x_wdata;
        logic [31:0] m_rdata;
        logic        e_gnt, e_stall, e_mre, e_mwe;
        logic [8:0]  e_maddr;
        logic [31:0] e_mwdata;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        chk_prd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic pr, input logic pw, input logic [8:0] pa, input logic [31:0] pd,
        input logic xr, input logic xw, input logic [8:0] xa, input logic [31:0] xd,
        input logic [31:0] mr,
        input logic g, input logic s, input logic re, input logic we,
        input logic [8:0] ma, input logic [31:0] md,
        input logic rv, input logic [31:0] rd, input logic cp);
        vec_t v;
        v.p_re = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
        v.x_req = xr; v.x_we = xw; v.x_addr = xa; v.x_wdata = xd;
        v.m_rdata = mr;
        v.e_gnt = g; v.e_stall = s; v.e_mre = re; v.e_mwe = we;
        v.e_maddr = ma; v.e_mwdata = md; v.e_rv = rv; v.e_rdata = rd;
        v.chk_prd = cp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        p_re = v.p_re; p_we = v.p_we; p_addr = v.p_addr; p_wdata = v.p_wdata;
        x_req = v.x_req; x_we = v.x_we; x_addr = v.x_addr; x_wdata = v.x_wdata;
        m_rdata = v.m_rdata;
    endtask

    initial begin
        logic [31:0] D;
        logic [31:0] ce;
        vec_t v;
        D = 32'hDEADBEEF;
        ce = 32'hCAFEF00D;
        p_funct3 = 3'b010;
        x_funct3 = 3'b101;

        // test 1/2: P load, X write, X read-back, back-to-back X reads
        tbl.push_back(mk(1,0,9'h010,0, 0,0,0,0, 32'h11112222, 0,0,1,0,9'h010,0, 0,0, 1));
        tbl.push_back(mk(0,0,0,0, 1,1,9'h020,D, 0, 1,0,0,1,9'h020,D, 0,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,0,9'h020,0, D, 1,0,1,0,9'h020,0, 0,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,0,9'h024,0, ce, 1,0,1,0,9'h024,0, 1,D, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 1,ce, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0, 0));
        // test 3: constant contention, period 6 (4 denied, forced, cooldown)
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                tbl.push_back(mk(0,1,9'h030,32'hAAAA, 1,1,9'h040,32'h5555, 0, 0,0,0,1,9'h030,32'hAAAA, 0,0, 0));
            tbl.push_back(mk(0,1,9'h030,32'hAAAA, 1,1,9'h040,32'h5555, 0, 1,1,0,1,9'h040,32'h5555, 0,0, 0));
            tbl.push_back(mk(0,1,9'h030,32'hAAAA, 1,1,9'h040,32'h5555, 0, 0,0,0,1,9'h030,32'hAAAA, 0,0, 0));
        end
        // test 4: forced X read while P loads
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,9'h050,0, 1,0,9'h060,0, 32'h01010101, 0,0,1,0,9'h050,0, 0,0, 1));
        tbl.push_back(mk(1,0,9'h050,0, 1,0,9'h060,0, 32'h12345678, 1,1,1,0,9'h060,0, 0,0, 0));
        tbl.push_back(mk(1,0,9'h050,0, 0,0,0,0, 32'h0BADF00D, 0,0,1,0,9'h050,0, 1,32'h12345678, 1));
        // test 6: x_req dropped in X_FORCE; cooldown must not count toward next force
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,9'h070,0, 1,0,9'h080,0, 0, 0,0,1,0,9'h070,0, 0,0, 0));
        tbl.push_back(mk(1,0,9'h070,0, 0,0,0,0, 0, 0,0,1,0,9'h070,0, 0,0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,0,9'h070,0, 1,0,9'h080,0, 0, 0,0,1,0,9'h070,0, 0,0, 0));
        tbl.push_back(mk(1,0,9'h070,0, 1,0,9'h080,0, 32'h77778888, 1,1,1,0,9'h080,0, 0,0, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 1,32'h77778888, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0, 0));

        // reset state, with requests active to show gating
        reset = 1'b1;
        v = mk(1,1,9'h011,1, 1,1,9'h022,2, 0, 0,0,0,0,0,0, 0,0, 0);
        drive(v);
        #1;
        check("reset_gating", {60'd0, x_gnt, p_stall, m_re, m_we}, 64'd0);
        @(posedge clk); #1;
        check("reset_regs", {31'd0, x_rvalid, x_rdata}, 64'd0);
        @(negedge clk);
        drive(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0, 0));
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i),
                {x_gnt, p_stall, m_re, m_we, m_addr, m_wdata, m_funct3, x_rvalid,
                 (tbl[i].e_rv ? x_rdata[11:0] : 12'd0)},
                {tbl[i].e_gnt, tbl[i].e_stall, tbl[i].e_mre, tbl[i].e_mwe, tbl[i].e_maddr,
                 tbl[i].e_mwdata, (tbl[i].e_gnt ? 3'b101 : 3'b010), tbl[i].e_rv,
                 tbl[i].e_rdata[11:0]});
            if (tbl[i].e_rv)
                check($sformatf("vec%0d_xrdata", i), {32'd0, x_rdata}, {32'd0, tbl[i].e_rdata});
            if (tbl[i].chk_prd)
                check($sformatf("vec%0d_prdata", i), {32'd0, p_rdata}, {32'd0, tbl[i].m_rdata});
        end

        // test 5: async reset during X_FORCE with an X read in flight
        v = mk(0,1,9'h030,32'hAAAA, 1,0,9'h040,0, 32'h5A5A5A5A, 0,0,0,0,0,0, 0,0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(v);
            #1;
            check($sformatf("pre_rst_gnt%0d", i), {62'd0, x_gnt, p_stall},
                  (i == 4) ? 64'd3 : 64'd0);
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst_drop", {60'd0, x_gnt, p_stall, m_re, m_we}, 64'd0);
        @(posedge clk); #1;
        check("async_rst_rvalid", {31'd0, x_rvalid, x_rdata}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("post_rst_gnt%0d", i), {62'd0, x_gnt, p_stall},
                  (i == 4) ? 64'd3 : 64'd0);
        end
        @(posedge clk); #1;
        check("post_rst_rvalid", {31'd0, x_rvalid, x_rdata}, {31'd0, 1'b1, 32'h5A5A5A5A});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
